serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor built around one full-subtractor cell (a, b, borrow-in -> diff, borrow-out) plus a borrow flip-flop.
- Loads two operands on start and processes one bit per clock, LSB first.
- Presents the registered difference and final borrow with a done pulse.
- Sits downstream of operand registers and upstream of any consumer of diff/borrow; trades the area of a ripple chain for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled when not busy
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/borrow update
- diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH
- borrow  output  1  registered final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Reset mid-operation aborts the job; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: capture a, b into shift regs, clear borrow flop, count=0, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1, done=0.
  - Each edge takes a0 = sa[0], b0 = sb[0], br = borrow flop:
    - bit d = a0 ^ b0 ^ br
    - bout = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d is shifted into a partial-result register from the MSB side.
    - sa and sb shift right; borrow flop <= bout; count++.
  - start is ignored in RUN; a and b may change freely.
  - After the WIDTH-th RUN edge (count reaches WIDTH), go to DONE. On that same edge: diff <= completed partial result, borrow <= final bout.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge: start=1 is accepted as in IDLE (back-to-back, go to RUN); start=0 goes to IDLE.
- Latency: start accepted at edge E0 -> diff/borrow valid and done=1 after edge E0+WIDTH.
  - Throughput: one result per WIDTH+1 cycles with start held high.
- diff and borrow change only on the completing edge.
  - Both hold their last value through IDLE, RUN and a new job until the next completion.
- Arithmetic: unsigned modulo 2^WIDTH. Equal operands give diff=0, borrow=0.
- Counter: width clog2(WIDTH+1); no wrap beyond WIDTH.

Test Plan:
- WIDTH=8, a=100, b=37, start pulse -> busy for 8 cycles; done=1 on cycle 9 after accept; diff=63 (0x3F), borrow=0.
- a=0x05, b=0x0A -> diff=0xFB, borrow=1. a=0x00, b=0xFF -> diff=0x01, borrow=1. a=b=0xFF -> diff=0x00, borrow=0.
- Exhaustive WIDTH=3 sweep of all 64 (a,b) pairs -> each result matches (a-b)&7 and (a<b). Also cross-checks every full-subtractor truth-table row.
- Start re-asserted mid-RUN with a=0xFF, b=0x00 -> ignored; the original job completes with its own result; no extra done.
- start held high continuously -> done pulses every 9 cycles; diff stays stable between pulses.
- rst asserted asynchronously at RUN cycle 4 -> busy, done, diff, borrow go to 0 immediately, without waiting for a clock edge. After release, a fresh job (a=0x80, b=0x01) -> diff=0x7F, borrow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit unsigned subtractor.
// One full-subtractor cell and a borrow flop process one operand bit per
// clock, LSB first. A job takes WIDTH RUN cycles; the result registers
// update only on the completing edge and done pulses for one cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset (aborts any job in flight)
//   start  - job request, sampled in IDLE and DONE
//   a, b   - minuend / subtrahend, captured when start is accepted
//   busy   - high while bits are being processed
//   done   - one-cycle pulse in the cycle diff/borrow hold a new result
//   diff   - registered (a - b) mod 2^WIDTH
//   borrow - registered final borrow, 1 iff a < b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Holds the WIDTH-1 result bits produced before the final edge; the
    // final bit is prepended directly when the result is committed.
    logic [WIDTH-2:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    // Full-subtractor cell on the current LSBs.
    logic a0, b0, d_bit, bout;
    always_comb begin
        a0    = sa_q[0];
        b0    = sb_q[0];
        d_bit = a0 ^ b0 ^ br_q;
        bout  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                br_d   = bout;
                cnt_d  = cnt_q + CW'(1);
                part_d = (WIDTH-1)'({d_bit, part_q} >> 1);
                if (cnt_q == LAST) begin
                    diff_d   = {d_bit, part_q};
                    borrow_d = bout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // Back-to-back: a new request is accepted straight from DONE.
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, borrow3;
    logic [2:0] diff3;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
    );

    // Stimulus only: issue one 8-bit job and return the number of edges
    // after the accepting edge until done is seen (-1 on timeout).
    // Entered and left 1 time unit after a rising edge.
    task automatic job8(input logic [7:0] av, input logic [7:0] bv, output int lat);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done8) begin lat = k; break; end
        end
    endtask

    task automatic job3(input logic [2:0] av, input logic [2:0] bv, output int lat);
        a3 = av; b3 = bv; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done3) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0) $display("FAIL reset8 got busy=%b done=%b diff=%h borrow=%b want all 0", busy8, done8, diff8, borrow8);
        else pass_cnt++;
        total++;
        if ({busy3, done3, diff3, borrow3} !== 6'd0) $display("FAIL reset3 got busy=%b done=%b diff=%h borrow=%b want all 0", busy3, done3, diff3, borrow3);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0) $display("FAIL idle_after_reset got busy=%b done=%b diff=%h want 0", busy8, done8, diff8);
        else pass_cnt++;
    endtask

    task automatic test_basic_timing();
        int lat;
        int bad_busy;
        bad_busy = 0;
        a8 = 8'd100; b8 = 8'd37; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (!(busy8 === 1'b1 && done8 === 1'b0 && diff8 === 8'h00)) bad_busy++;
            @(posedge clk); #1;
        end
        total++;
        if (bad_busy != 0) $display("FAIL basic_busy got %0d bad RUN cycles want 0", bad_busy);
        else pass_cnt++;
        total++;
        if (!(done8 === 1'b1 && busy8 === 1'b0)) $display("FAIL basic_done got done=%b busy=%b want done=1 busy=0", done8, busy8);
        else pass_cnt++;
        total++;
        if (diff8 !== 8'h3F || borrow8 !== 1'b0) $display("FAIL basic_result got diff=%h borrow=%b want 3f 0", diff8, borrow8);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== 8'h3F) $display("FAIL basic_after got done=%b busy=%b diff=%h want 0 0 3f", done8, busy8, diff8);
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'h05, 8'h00, 8'hFF, 8'h64};
        logic [7:0] vb [4] = '{8'h0A, 8'hFF, 8'hFF, 8'h25};
        logic [7:0] vd [4] = '{8'hFB, 8'h01, 8'h00, 8'h3F};
        logic       vw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            job8(va[i], vb[i], lat);
            total++;
            if (lat != 8) $display("FAIL vec%0d_latency got %0d want 8", i, lat);
            else pass_cnt++;
            total++;
            if (diff8 !== vd[i] || borrow8 !== vw[i])
                $display("FAIL vec%0d_result a=%h b=%h got diff=%h borrow=%b want %h %b", i, va[i], vb[i], diff8, borrow8, vd[i], vw[i]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep3();
        int lat;
        int bad;
        logic [2:0] ed;
        logic       eb;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                job3(3'(i), 3'(j), lat);
                ed = 3'(i - j);
                eb = (i < j);
                total++;
                if (lat != 3 || diff3 !== ed || borrow3 !== eb) begin
                    $display("FAIL sweep3 a=%0d b=%0d got diff=%0d borrow=%b lat=%0d want %0d %b 3", i, j, diff3, borrow3, lat, ed, eb);
                    bad++;
                end else pass_cnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat;
        int extra;
        a8 = 8'h10; b8 = 8'h03; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1; end
            if (k == 6) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin lat = k; break; end
        end
        total++;
        if (lat != 8) $display("FAIL ignore_latency got %0d want 8", lat);
        else pass_cnt++;
        total++;
        if (diff8 !== 8'h0D || borrow8 !== 1'b0) $display("FAIL ignore_result got diff=%h borrow=%b want 0d 0", diff8, borrow8);
        else pass_cnt++;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) extra++;
        end
        total++;
        if (extra != 0) $display("FAIL ignore_no_extra got %0d busy/done cycles want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad_done;
        int bad_diff;
        bad_done = 0;
        bad_diff = 0;
        a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1;
            if (done8 !== ((k % 9) == 8)) begin
                bad_done++;
                $display("FAIL b2b_done edge=%0d got %b want %b", k, done8, ((k % 9) == 8));
            end
            if (k >= 8 && diff8 !== 8'h1F) bad_diff++;
        end
        start8 = 1'b0;
        total++;
        if (bad_done != 0) $display("FAIL b2b_pulses got %0d wrong cycles want 0", bad_done);
        else pass_cnt++;
        total++;
        if (bad_diff != 0) $display("FAIL b2b_diff_stable got %0d wrong cycles want 0", bad_diff);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat;
        int spurious;
        a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (busy8 !== 1'b1 || diff8 !== 8'h1F) $display("FAIL arst_pre got busy=%b diff=%h want 1 1f", busy8, diff8);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0) $display("FAIL arst_immediate got busy=%b done=%b diff=%h borrow=%b want all 0", busy8, done8, diff8, borrow8);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8 || diff8 !== 8'h00) spurious++;
        end
        total++;
        if (spurious != 0) $display("FAIL arst_abort got %0d active cycles want 0", spurious);
        else pass_cnt++;
        job8(8'h80, 8'h01, lat);
        total++;
        if (lat != 8 || diff8 !== 8'h7F || borrow8 !== 1'b0) $display("FAIL arst_fresh got diff=%h borrow=%b lat=%0d want 7f 0 8", diff8, borrow8, lat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_vectors();
        test_sweep3();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
